usb_hub_port_scheduler: RTL and testbench

Parametrised downstream-port scheduler for the USB hub. It buffers byte-wide packets per port and arbitrates the ports round-robin onto a single shared serializer stream. Only complete packets from attached ports are granted, so a packet is never interleaved or started before its last byte arrives. It sits between the per-port packet sources and the shared PISO/transceiver path.

---
 rtl/usb_hub_pkg.sv | 31 +++
 rtl/usb_hub_pkt_fifo.sv | 102 ++++++++++
 rtl/usb_hub_port_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_usb_hub_port_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_hub_pkg.sv
// -----------------------------------------------------------------------------
// usb_hub_pkg
// Shared definitions for the USB hub downstream-port scheduler:
//   - sched_state_e : scheduler FSM states (IDLE, STREAM)
//   - calc_pw       : width of a port index (at least 1 bit)
//   - calc_cw       : width of a per-port packet counter (0..depth inclusive)
// -----------------------------------------------------------------------------
package usb_hub_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_e;

    // A single-port hub still carries a 1-bit port index so ports never collapse to zero width.
    function automatic int calc_pw(input int num_ports);
        int w;
        if (num_ports <= 1) begin
            w = 1;
        end else begin
            w = $clog2(num_ports);
        end
        return w;
    endfunction

    // Counter must represent every value from 0 up to and including depth.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/usb_hub_pkt_fifo.sv
// -----------------------------------------------------------------------------
// usb_hub_pkt_fifo
// First-word-fall-through FIFO of {last, data} entries for one downstream port,
// with a count of complete packets held and a synchronous flush.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   flush                 : clears pointers and packet count; beats a same-cycle write
//   wr_en/wr_data/wr_last : write request (ignored while full)
//   rd_en                 : pop the head entry (ignored while empty)
//   head_data/head_last   : entry at the read pointer
//   next_data/next_last   : entry just behind the head (used to preload the
//                           registered output stage on a pop)
//   full, empty           : pointer-equality status using the wrap bit
//   pkt_cnt               : number of complete packets stored
// -----------------------------------------------------------------------------
module usb_hub_pkt_fifo
    import usb_hub_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int CW    = calc_cw(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          rd_en,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [DW-1:0] next_data,
    output logic          next_last,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] pkt_cnt
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [DW:0]   mem_q [DEPTH];
    logic          do_wr_s;
    logic          do_rd_s;
    logic [AW-1:0] next_idx_s;

    // Same index with different wrap bits means the writer is a full lap ahead.
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign do_wr_s    = wr_en & ~full;
    assign do_rd_s    = rd_en & ~empty;
    assign next_idx_s = rd_ptr_q[AW-1:0] + PTR_ONE[AW-1:0];

    assign {head_last, head_data} = mem_q[rd_ptr_q[AW-1:0]];
    assign {next_last, next_data} = mem_q[next_idx_s];
    assign pkt_cnt                = pkt_cnt_q;

    // Next-state pointers and packet count; flush overrides any traffic.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (flush) begin
            wr_ptr_d  = {(AW+1){1'b0}};
            rd_ptr_d  = {(AW+1){1'b0}};
            pkt_cnt_d = {CW{1'b0}};
        end else begin
            wr_ptr_d = do_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = do_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            // A packet completing and one leaving in the same cycle cancel out.
            case ({do_wr_s & wr_last, do_rd_s & head_last})
                2'b10:   pkt_cnt_d = pkt_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   pkt_cnt_d = pkt_cnt_q - {{(CW-1){1'b0}}, 1'b1};
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    // Pointer and packet-count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= {(AW+1){1'b0}};
            rd_ptr_q  <= {(AW+1){1'b0}};
            pkt_cnt_q <= {CW{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Storage array; a flushed write is discarded.
    always_ff @(posedge clock) begin
        if (do_wr_s && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
        end
    end

endmodule

// File: rtl/usb_hub_port_scheduler.sv
// -----------------------------------------------------------------------------
// usb_hub_port_scheduler
// Buffers byte packets per downstream port and streams complete packets from
// attached ports, one at a time and round-robin, onto the shared serializer.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   port_attached[NUM_PORTS]     : per-port attach status; detach flushes the port
//   wr_data/wr_val/wr_last       : per-port byte writes (port i at slice i)
//   wr_ready[NUM_PORTS]          : attached and not full
//   out_data/out_val/out_last    : granted byte stream (registered)
//   out_port                     : index of granted port (registered)
//   out_ready                    : serializer consumes the current byte
//   out_abort                    : pulse when the granted port detaches mid-packet
//   port_overflow[NUM_PORTS]     : pulse when a port is flushed on overflow
//   pkt_pending[NUM_PORTS]       : port holds at least one complete packet
// -----------------------------------------------------------------------------
module usb_hub_port_scheduler
    import usb_hub_pkg::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int FIFO_DEPTH = 8,
    parameter  int DATA_WIDTH = 8,
    localparam int PW         = calc_pw(NUM_PORTS),
    localparam int CW         = calc_cw(FIFO_DEPTH)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_attached,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_PORTS-1:0]            wr_val,
    input  logic [NUM_PORTS-1:0]            wr_last,
    output logic [NUM_PORTS-1:0]            wr_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_val,
    output logic                            out_last,
    output logic [PW-1:0]                   out_port,
    input  logic                            out_ready,
    output logic                            out_abort,
    output logic [NUM_PORTS-1:0]            port_overflow,
    output logic [NUM_PORTS-1:0]            pkt_pending
);

    // First set bit of req at or after start, wrapping; MSB of result = found.
    function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [PW-1:0]        start);
        logic          found;
        logic [PW-1:0] sel;
        logic [PW-1:0] cand;
        int            idx;
        found = 1'b0;
        sel   = {PW{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx  = (int'(start) + k) % NUM_PORTS;
            cand = idx[PW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] cur);
        logic [PW-1:0] nxt;
        if (int'(cur) >= NUM_PORTS - 1) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = cur + {{(PW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    logic [NUM_PORTS-1:0]  full_s, empty_s, flush_s, overflow_s;
    logic [NUM_PORTS-1:0]  fifo_wr_s, fifo_rd_s, head_last_s, next_last_s;
    logic [NUM_PORTS-1:0]  eligible_s;
    logic [DATA_WIDTH-1:0] head_data_s [NUM_PORTS];
    logic [DATA_WIDTH-1:0] next_data_s [NUM_PORTS];
    logic [CW-1:0]         pkt_cnt_s   [NUM_PORTS];
    logic [PW:0]           pick_s;
    logic [PW-1:0]         pick_idx_s;

    sched_state_e          state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         out_port_q, out_port_d;
    logic                  out_val_q, out_val_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_abort_q, out_abort_d;
    logic [NUM_PORTS-1:0]  port_overflow_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign wr_ready[i]    = port_attached[i] & ~full_s[i];
        assign fifo_wr_s[i]   = wr_val[i] & wr_ready[i];
        assign fifo_rd_s[i]   = out_val_q & out_ready & ~empty_s[i] & (out_port_q == PW'(i));
        // Full with no complete packet: the packet in flight can never finish.
        assign overflow_s[i]  = full_s[i] & (pkt_cnt_s[i] == {CW{1'b0}});
        assign flush_s[i]     = ~port_attached[i] | overflow_s[i];
        assign pkt_pending[i] = (pkt_cnt_s[i] != {CW{1'b0}});

        usb_hub_pkt_fifo #(
            .DEPTH (FIFO_DEPTH),
            .DW    (DATA_WIDTH),
            .CW    (CW)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush_s[i]),
            .wr_en     (fifo_wr_s[i]),
            .wr_data   (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .wr_last   (wr_last[i]),
            .rd_en     (fifo_rd_s[i]),
            .head_data (head_data_s[i]),
            .head_last (head_last_s[i]),
            .next_data (next_data_s[i]),
            .next_last (next_last_s[i]),
            .full      (full_s[i]),
            .empty     (empty_s[i]),
            .pkt_cnt   (pkt_cnt_s[i])
        );
    end

    assign eligible_s = port_attached & pkt_pending;
    assign pick_s     = rr_pick(eligible_s, rr_ptr_q);
    assign pick_idx_s = pick_s[PW-1:0];

    // Scheduler next state. The output byte is registered, so a pop preloads
    // the entry behind the head; it always exists because only complete
    // packets are granted.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_port_d  = out_port_q;
        out_val_d   = out_val_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_s[PW]) begin
                    state_d    = STREAM;
                    out_port_d = pick_idx_s;
                    out_val_d  = 1'b1;
                    out_data_d = head_data_s[pick_idx_s];
                    out_last_d = head_last_s[pick_idx_s];
                end else begin
                    state_d   = IDLE;
                    out_val_d = 1'b0;
                end
            end
            STREAM: begin
                if (!port_attached[out_port_q]) begin
                    // Granted port detached: its flush registers this edge.
                    state_d     = IDLE;
                    out_val_d   = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = {DATA_WIDTH{1'b0}};
                    out_abort_d = 1'b1;
                    rr_ptr_d    = rr_next(out_port_q);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        state_d    = IDLE;
                        out_val_d  = 1'b0;
                        out_last_d = 1'b0;
                        out_data_d = {DATA_WIDTH{1'b0}};
                        rr_ptr_d   = rr_next(out_port_q);
                    end else begin
                        out_data_d = next_data_s[out_port_q];
                        out_last_d = next_last_s[out_port_q];
                    end
                end else begin
                    out_data_d = out_data_q;
                    out_last_d = out_last_q;
                end
            end
            default: begin
                state_d    = IDLE;
                out_val_d  = 1'b0;
                out_last_d = 1'b0;
                out_data_d = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Scheduler FSM and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= {PW{1'b0}};
            out_port_q      <= {PW{1'b0}};
            out_val_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= {DATA_WIDTH{1'b0}};
            out_abort_q     <= 1'b0;
            port_overflow_q <= {NUM_PORTS{1'b0}};
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            out_port_q      <= out_port_d;
            out_val_q       <= out_val_d;
            out_last_q      <= out_last_d;
            out_data_q      <= out_data_d;
            out_abort_q     <= out_abort_d;
            port_overflow_q <= overflow_s;
        end
    end

    assign out_data      = out_data_q;
    assign out_val       = out_val_q;
    assign out_last      = out_last_q;
    assign out_port      = out_port_q;
    assign out_abort     = out_abort_q;
    assign port_overflow = port_overflow_q;

endmodule

// File: tb/tb_usb_hub_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_usb_hub_port_scheduler
// Directed bench for the downstream-port scheduler (2 ports, 4-deep FIFOs).
// -----------------------------------------------------------------------------
module tb_usb_hub_port_scheduler;

    logic        clock;
    logic        reset;
    logic [1:0]  port_attached;
    logic [15:0] wr_data;
    logic [1:0]  wr_val;
    logic [1:0]  wr_last;
    logic [1:0]  wr_ready;
    logic [7:0]  out_data;
    logic        out_val;
    logic        out_last;
    logic [0:0]  out_port;
    logic        out_ready;
    logic        out_abort;
    logic [1:0]  port_overflow;
    logic [1:0]  pkt_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected stream after the first round-robin pop (one entry per cycle).
    int rr_v [7] = '{0, 1, 0, 1, 0, 1, 0};
    int rr_p [7] = '{0, 1, 0, 0, 0, 1, 0};
    int rr_d [7] = '{0, 'h20, 0, 'h11, 0, 'h21, 0};

    usb_hub_port_scheduler #(
        .NUM_PORTS  (2),
        .FIFO_DEPTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .port_attached (port_attached),
        .wr_data       (wr_data),
        .wr_val        (wr_val),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .out_data      (out_data),
        .out_val       (out_val),
        .out_last      (out_last),
        .out_port      (out_port),
        .out_ready     (out_ready),
        .out_abort     (out_abort),
        .port_overflow (port_overflow),
        .pkt_pending   (pkt_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic val, input logic [0:0] port,
                              input logic [7:0] data, input logic last);
        check_eq({tag, ".val"}, {31'd0, out_val}, {31'd0, val});
        check_eq({tag, ".port"}, {31'd0, out_port}, {31'd0, port});
        check_eq({tag, ".data"}, {24'd0, out_data}, {24'd0, data});
        check_eq({tag, ".last"}, {31'd0, out_last}, {31'd0, last});
    endtask

    task automatic drive_wr(input int port, input logic [7:0] data, input logic last);
        wr_data[port*8 +: 8] = data;
        wr_val[port]         = 1'b1;
        wr_last[port]        = last;
    endtask

    task automatic clear_wr();
        wr_val  = 2'b00;
        wr_last = 2'b00;
    endtask

    initial begin
        reset         = 1'b1;
        port_attached = 2'b00;
        wr_data       = 16'h0000;
        wr_val        = 2'b00;
        wr_last       = 2'b00;
        out_ready     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        expect_out("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("reset.abort", {31'd0, out_abort}, 32'd0);
        check_eq("reset.ovf", {30'd0, port_overflow}, 32'd0);
        check_eq("reset.pend", {30'd0, pkt_pending}, 32'd0);
        check_eq("reset.wr_ready", {30'd0, wr_ready}, 32'd0);
        port_attached = 2'b10;
        #1;
        check_eq("attach.wr_ready", {30'd0, wr_ready}, 32'h2);

        // Single packet on port 1
        out_ready = 1'b1;
        drive_wr(1, 8'hA1, 1'b0); tick();
        drive_wr(1, 8'hA2, 1'b0); tick();
        drive_wr(1, 8'hA3, 1'b1); tick();
        clear_wr();
        check_eq("single.pend", {30'd0, pkt_pending}, 32'h2);
        check_eq("single.noval", {31'd0, out_val}, 32'd0);
        tick(); expect_out("single.b0", 1'b1, 1'b1, 8'hA1, 1'b0);
        tick(); expect_out("single.b1", 1'b1, 1'b1, 8'hA2, 1'b0);
        tick(); expect_out("single.b2", 1'b1, 1'b1, 8'hA3, 1'b1);
        tick();
        check_eq("single.done", {31'd0, out_val}, 32'd0);
        check_eq("single.pend0", {30'd0, pkt_pending}, 32'd0);

        // Round robin: two single-byte packets per port
        port_attached = 2'b11;
        out_ready     = 1'b0;
        drive_wr(0, 8'h10, 1'b1); drive_wr(1, 8'h20, 1'b1); tick();
        drive_wr(0, 8'h11, 1'b1); drive_wr(1, 8'h21, 1'b1); tick();
        clear_wr();
        expect_out("rr.first", 1'b1, 1'b0, 8'h10, 1'b1);
        check_eq("rr.pend", {30'd0, pkt_pending}, 32'h3);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq($sformatf("rr.val%0d", k), {31'd0, out_val}, rr_v[k]);
            if (rr_v[k] != 0) begin
                check_eq($sformatf("rr.port%0d", k), {31'd0, out_port}, rr_p[k]);
                check_eq($sformatf("rr.data%0d", k), {24'd0, out_data}, rr_d[k]);
            end
        end
        check_eq("rr.pend0", {30'd0, pkt_pending}, 32'd0);

        // Backpressure on port 1 with out_ready 1,0,0,1
        out_ready = 1'b0;
        drive_wr(1, 8'hB1, 1'b0); tick();
        drive_wr(1, 8'hB2, 1'b0); tick();
        drive_wr(1, 8'hB3, 1'b1); tick();
        clear_wr();
        tick(); expect_out("bp.b1", 1'b1, 1'b1, 8'hB1, 1'b0);
        out_ready = 1'b1;
        tick(); expect_out("bp.b2", 1'b1, 1'b1, 8'hB2, 1'b0);
        out_ready = 1'b0;
        tick(); expect_out("bp.hold1", 1'b1, 1'b1, 8'hB2, 1'b0);
        tick(); expect_out("bp.hold2", 1'b1, 1'b1, 8'hB2, 1'b0);
        out_ready = 1'b1;
        tick(); expect_out("bp.b3", 1'b1, 1'b1, 8'hB3, 1'b1);
        tick();
        check_eq("bp.done", {31'd0, out_val}, 32'd0);

        // Partial packet on port 0 is not granted until its last byte
        drive_wr(0, 8'hC1, 1'b0); tick();
        drive_wr(0, 8'hC2, 1'b0); tick();
        clear_wr();
        tick(); tick();
        check_eq("part.pend", {30'd0, pkt_pending}, 32'd0);
        check_eq("part.noval", {31'd0, out_val}, 32'd0);
        drive_wr(0, 8'hC3, 1'b1); tick();
        clear_wr();
        check_eq("part.pend1", {30'd0, pkt_pending}, 32'h1);
        tick(); expect_out("part.c1", 1'b1, 1'b0, 8'hC1, 1'b0);
        tick(); expect_out("part.c2", 1'b1, 1'b0, 8'hC2, 1'b0);
        tick(); expect_out("part.c3", 1'b1, 1'b0, 8'hC3, 1'b1);
        tick();
        check_eq("part.done", {31'd0, out_val}, 32'd0);

        // Overflow: four bytes without last fill port 0
        for (int k = 0; k < 4; k++) begin
            drive_wr(0, 8'h31 + 8'(k), 1'b0);
            tick();
        end
        clear_wr();
        check_eq("ovf.full", {30'd0, wr_ready}, 32'h2);
        check_eq("ovf.nopulse", {30'd0, port_overflow}, 32'd0);
        tick();
        check_eq("ovf.pulse", {30'd0, port_overflow}, 32'h1);
        check_eq("ovf.ready", {30'd0, wr_ready}, 32'h3);
        check_eq("ovf.pend", {30'd0, pkt_pending}, 32'd0);
        check_eq("ovf.noval", {31'd0, out_val}, 32'd0);
        tick();
        check_eq("ovf.once", {30'd0, port_overflow}, 32'd0);
        drive_wr(0, 8'hD1, 1'b1); tick();
        clear_wr();
        tick(); expect_out("ovf.d1", 1'b1, 1'b0, 8'hD1, 1'b1);
        tick();
        check_eq("ovf.done", {31'd0, out_val}, 32'd0);

        // Detach of the granted port mid-packet
        out_ready = 1'b0;
        drive_wr(0, 8'hE0, 1'b0); tick();
        drive_wr(0, 8'hE1, 1'b0); tick();
        drive_wr(0, 8'hE2, 1'b1); tick();
        clear_wr();
        drive_wr(1, 8'hF0, 1'b1); tick();
        clear_wr();
        expect_out("det.e0", 1'b1, 1'b0, 8'hE0, 1'b0);
        out_ready = 1'b1;
        tick(); expect_out("det.e1", 1'b1, 1'b0, 8'hE1, 1'b0);
        port_attached = 2'b10;
        tick();
        check_eq("det.abort", {31'd0, out_abort}, 32'd1);
        check_eq("det.noval", {31'd0, out_val}, 32'd0);
        check_eq("det.pend", {30'd0, pkt_pending}, 32'h2);
        check_eq("det.ready", {30'd0, wr_ready}, 32'h2);
        tick();
        expect_out("det.f0", 1'b1, 1'b1, 8'hF0, 1'b1);
        check_eq("det.abort_once", {31'd0, out_abort}, 32'd0);
        tick();
        check_eq("det.done", {31'd0, out_val}, 32'd0);
        check_eq("det.pend0", {30'd0, pkt_pending}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
